pw_sequence_checker: RTL and testbench
======================================

PW_SEQUENCE_CHECKER -- requirements
Module: pw_sequence_checker

Interface
REQ-001 Parameter CODE, default 8'h2D, password as four 2-bit button indices; slot k (k=0 first press) = CODE[7-2k -: 2]; a=0, b=1, c=2, d=3 (default sequence a,c,d,b).
REQ-002 Parameter TIMEOUT_CYCLES, default 250_000_000, max idle cycles between presses during entry.
REQ-003 Parameter UNLOCK_CYCLES, default 500_000_000, duration of unlock indication.
REQ-004 Parameter MAX_FAILS, default 3, consecutive failed entries before lockout (range 1..3).
REQ-005 Parameter LOCK_CYCLES, default 1_000_000_000, lockout duration.
REQ-006 clkin  input  1  single clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 btn  input  4  debounced button levels, bit0=a, bit1=b, bit2=c, bit3=d, synchronous to clkin.
REQ-009 unlock  output  1  high while in UNLOCKED.
REQ-010 fail  output  1  one-cycle pulse on each failed 4-press entry.
REQ-011 timeout  output  1  one-cycle pulse when an entry is abandoned for inactivity.
REQ-012 locked  output  1  high while in LOCKOUT.
REQ-013 digits  output  3  presses accepted in current entry, 0..4.
REQ-014 fail_count  output  2  consecutive failed entries, 0..MAX_FAILS.

Function
REQ-015 Press detection: btn_q registers btn each cycle; press = btn & ~btn_q; a press is valid in a cycle when press is nonzero.
REQ-016 Press with exactly one bit set carries that bit's index; press with two or more bits set is a press that mismatches its slot unconditionally.
REQ-017 States: IDLE, COLLECT, UNLOCKED, LOCKOUT; one shared down-counter serves timeout, unlock and lockout timing.
REQ-018 IDLE: valid press -> COLLECT, digits=1, mismatch flag = (index != slot 0), counter loaded TIMEOUT_CYCLES-1.
REQ-019 COLLECT: each valid press increments digits, ORs its mismatch into the sticky flag, reloads counter.
REQ-020 COLLECT, fourth press, flag clear (including this press) -> UNLOCKED, counter=UNLOCK_CYCLES-1, fail_count=0, digits=0.
REQ-021 COLLECT, fourth press, flag set -> fail pulse next cycle, fail_count+1, digits=0; if new fail_count==MAX_FAILS -> LOCKOUT, counter=LOCK_CYCLES-1, else -> IDLE.
REQ-022 COLLECT, counter reaches 0 with no press in that cycle -> IDLE, timeout pulse, digits=0, fail_count unchanged; a press in the same cycle as counter==0 takes priority over timeout.
REQ-023 UNLOCKED: presses ignored; counter==0 -> IDLE.
REQ-024 LOCKOUT: presses ignored; counter==0 -> IDLE, fail_count=0.
REQ-025 All outputs registered; unlock/locked rise the cycle after the clock edge capturing the deciding press; fail and timeout high exactly one cycle.
REQ-026 Ignored presses still update btn_q, so a button held across a state exit generates no press.

Reset
REQ-027 reset low: state=IDLE, counter=0, flag=0, digits=0, fail_count=0, unlock=0, fail=0, timeout=0, locked=0.
REQ-028 btn_q resets to 4'b1111 so buttons held through reset release register no press.
REQ-029 Reset mid-entry, mid-unlock or mid-lockout discards all progress with no fail or timeout pulse.

Structure
REQ-030 Shared package pw_pkg holds state encoding and button index constants (BTN_A..BTN_D).
REQ-031 Press detection (btn_q register, edge mask, single-hot check, index encode) is sub-module press_edge_detect; FSM, counter and outputs stay in pw_sequence_checker.

Verification (bench params TIMEOUT_CYCLES=20, UNLOCK_CYCLES=10, LOCK_CYCLES=30, MAX_FAILS=3, CODE=8'h2D)
REQ-032 Press a,c,d,b, 5 cycles apart -> unlock high exactly 10 cycles, fail_count=0, digits back to 0.
REQ-033 Press a,c,c,b -> single fail pulse after 4th press, fail_count=1, unlock never high; three such entries -> locked high 30 cycles, then fail_count=0.
REQ-034 Press a,c then idle 25 cycles -> timeout pulse 20 cycles after 2nd press, digits=0, fail_count unchanged.
REQ-035 a and c rising same cycle as first press, then d,b,a -> fail pulse after 4th press.
REQ-036 Hold btn=4'b0001 through reset release -> no press counted, digits stays 0 until a new rising edge.
REQ-037 Assert reset during COLLECT at digits=3 and during LOCKOUT -> all outputs 0 next cycle, no fail/timeout pulse.

Source files
------------

// File: rtl/pw_pkg.sv
// Shared definitions for the password sequence checker: FSM states,
// button index constants and the password slot lookup.
package pw_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } pw_state_e;

    localparam logic [1:0] BTN_A = 2'd0;
    localparam logic [1:0] BTN_B = 2'd1;
    localparam logic [1:0] BTN_C = 2'd2;
    localparam logic [1:0] BTN_D = 2'd3;

    // Slot k of the password; slot 0 is the first press, stored in the top bits.
    function automatic logic [1:0] codeSlot(input logic [7:0] code, input logic [1:0] k);
        case (k)
            2'd0:    return code[7:6];
            2'd1:    return code[5:4];
            2'd2:    return code[3:2];
            default: return code[1:0];
        endcase
    endfunction

endpackage

// File: rtl/pw_sequence_checker_if.sv
// Button inputs and status outputs of the password sequence checker.
// The master side drives the buttons, the slave side is the checker.
interface pw_sequence_checker_if;

    logic [3:0] btn;
    logic       unlock;
    logic       fail;
    logic       timeout;
    logic       locked;
    logic [2:0] digits;
    logic [1:0] fail_count;

    modport master (
        output btn,
        input  unlock, fail, timeout, locked, digits, fail_count
    );

    modport slave (
        input  btn,
        output unlock, fail, timeout, locked, digits, fail_count
    );

endinterface

// File: rtl/press_edge_detect.sv
// Rising-edge press detector for the four buttons: flags a press, whether
// more than one button rose together, and the index of a single press.
module press_edge_detect
    import pw_pkg::*;
(
    input  logic       clkin,
    input  logic       reset,
    input  logic [3:0] btn_i,
    output logic       valid_o,
    output logic       multi_o,
    output logic [1:0] idx_o
);

    logic [3:0] btn_q;
    logic [3:0] press;

    // Reset to all-ones so a button held through reset release is not a press.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            btn_q <= 4'b1111;
        end else begin
            btn_q <= btn_i;
        end
    end

    assign press   = btn_i & ~btn_q;
    assign valid_o = |press;
    assign multi_o = valid_o && !$onehot(press);

    always_comb begin
        idx_o = BTN_A;
        case (press)
            4'b0010: idx_o = BTN_B;
            4'b0100: idx_o = BTN_C;
            4'b1000: idx_o = BTN_D;
            default: idx_o = BTN_A;
        endcase
    end

endmodule

// File: rtl/pw_sequence_checker.sv
// Four-press password checker with inactivity timeout, timed unlock and
// lockout after repeated failures; one down-counter times every state.
module pw_sequence_checker
    import pw_pkg::*;
#(
    parameter logic [7:0]  CODE           = 8'h2D,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
    parameter int unsigned UNLOCK_CYCLES  = 500_000_000,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCK_CYCLES    = 1_000_000_000
) (
    input logic                  clkin,
    input logic                  reset,
    pw_sequence_checker_if.slave bus
);

    localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] UNLOCK_LOAD  = 32'(UNLOCK_CYCLES - 1);
    localparam logic [31:0] LOCK_LOAD    = 32'(LOCK_CYCLES - 1);
    localparam logic [1:0]  FAIL_LIMIT   = 2'(MAX_FAILS);

    pw_state_e   state_q;
    logic [31:0] counter_q;
    logic        mismatch_q;
    logic [2:0]  digits_q;
    logic [1:0]  failCount_q;
    logic        unlock_q;
    logic        fail_q;
    logic        timeout_q;
    logic        locked_q;

    logic        pressValid;
    logic        pressMulti;
    logic [1:0]  pressIdx;
    logic        pressMismatch;
    logic        mismatch_d;
    logic [1:0]  failCount_d;

    press_edge_detect u_press (
        .clkin   (clkin),
        .reset   (reset),
        .btn_i   (bus.btn),
        .valid_o (pressValid),
        .multi_o (pressMulti),
        .idx_o   (pressIdx)
    );

    // digits_q is 0 in IDLE, so it always names the slot the current press fills.
    assign pressMismatch = pressMulti || (pressIdx != codeSlot(CODE, digits_q[1:0]));
    assign mismatch_d    = mismatch_q | pressMismatch;
    assign failCount_d   = failCount_q + 2'd1;

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            counter_q   <= '0;
            mismatch_q  <= 1'b0;
            digits_q    <= '0;
            failCount_q <= '0;
            unlock_q    <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pressValid) begin
                        state_q    <= COLLECT;
                        digits_q   <= 3'd1;
                        mismatch_q <= pressMismatch;
                        counter_q  <= TIMEOUT_LOAD;
                    end
                end
                COLLECT: begin
                    if (pressValid && digits_q == 3'd3) begin
                        digits_q   <= '0;
                        mismatch_q <= 1'b0;
                        if (!mismatch_d) begin
                            state_q     <= UNLOCKED;
                            unlock_q    <= 1'b1;
                            counter_q   <= UNLOCK_LOAD;
                            failCount_q <= '0;
                        end else begin
                            fail_q      <= 1'b1;
                            failCount_q <= failCount_d;
                            if (failCount_d == FAIL_LIMIT) begin
                                state_q   <= LOCKOUT;
                                locked_q  <= 1'b1;
                                counter_q <= LOCK_LOAD;
                            end else begin
                                state_q   <= IDLE;
                                counter_q <= '0;
                            end
                        end
                    end else if (pressValid) begin
                        digits_q   <= digits_q + 3'd1;
                        mismatch_q <= mismatch_d;
                        counter_q  <= TIMEOUT_LOAD;
                    end else if (counter_q == '0) begin
                        state_q    <= IDLE;
                        timeout_q  <= 1'b1;
                        digits_q   <= '0;
                        mismatch_q <= 1'b0;
                    end else begin
                        counter_q <= counter_q - 32'd1;
                    end
                end
                UNLOCKED: begin
                    if (counter_q == '0) begin
                        state_q  <= IDLE;
                        unlock_q <= 1'b0;
                    end else begin
                        counter_q <= counter_q - 32'd1;
                    end
                end
                LOCKOUT: begin
                    if (counter_q == '0) begin
                        state_q     <= IDLE;
                        locked_q    <= 1'b0;
                        failCount_q <= '0;
                    end else begin
                        counter_q <= counter_q - 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.unlock     = unlock_q;
    assign bus.fail       = fail_q;
    assign bus.timeout    = timeout_q;
    assign bus.locked     = locked_q;
    assign bus.digits     = digits_q;
    assign bus.fail_count = failCount_q;

endmodule

// File: tb/tb_pw_sequence_checker.sv
// Self-checking bench for pw_sequence_checker: a behavioural model of the
// password rules is compared against the DUT on every falling clock edge.
module tb_pw_sequence_checker;

    localparam int TO = 20;
    localparam int UL = 10;
    localparam int LK = 30;
    localparam int MF = 3;

    localparam logic [3:0] KA = 4'b0001;
    localparam logic [3:0] KB = 4'b0010;
    localparam logic [3:0] KC = 4'b0100;
    localparam logic [3:0] KD = 4'b1000;

    logic clkin;
    logic reset;
    logic checkEn;

    int vectors;
    int miscompares;
    int cyc;

    int unlockHigh;
    int lockedHigh;
    int failPulses;
    int timeoutPulses;
    int tTimeout;
    int tPress;

    // Password a,c,d,b written out by hand from CODE = 8'h2D.
    int codeSeq[4] = '{0, 2, 3, 1};

    // Model state: presses of the open entry and time left on indications.
    logic [3:0] mPrev       = 4'b1111;
    int         mEntry[$];
    int         mIdle       = 0;
    int         mUnlockLeft = 0;
    int         mLockLeft   = 0;
    int         mFails      = 0;
    logic       eFail       = 1'b0;
    logic       eTimeout    = 1'b0;

    pw_sequence_checker_if iface();

    pw_sequence_checker #(
        .CODE           (8'h2D),
        .TIMEOUT_CYCLES (TO),
        .UNLOCK_CYCLES  (UL),
        .MAX_FAILS      (MF),
        .LOCK_CYCLES    (LK)
    ) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (iface)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clkin);
            cyc++;
        end
    end

    function automatic int idxOf(input logic [3:0] p);
        for (int i = 0; i < 4; i++) begin
            if (p[i]) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] b, input int cycles);
        iface.btn = b;
        repeat (cycles) @(negedge clkin);
    endtask

    task automatic pressKey(input logic [3:0] b, input int gap);
        applyStimulus(b, 1);
        applyStimulus(4'b0000, gap - 1);
    endtask

    task automatic enterCode(input logic [3:0] k0, input logic [3:0] k1,
                             input logic [3:0] k2, input logic [3:0] k3);
        pressKey(k0, 5);
        pressKey(k1, 5);
        pressKey(k2, 5);
        pressKey(k3, 5);
    endtask

    // Model advances on each rising edge: an active indication swallows presses,
    // otherwise presses extend the entry, which is judged once it holds four.
    initial begin
        logic [3:0] press;
        logic       good;
        forever begin
            @(posedge clkin or negedge reset);
            if (!reset) begin
                mPrev = 4'b1111;
                mEntry.delete();
                mIdle = 0;
                mUnlockLeft = 0;
                mLockLeft = 0;
                mFails = 0;
                eFail = 1'b0;
                eTimeout = 1'b0;
            end else begin
                press = iface.btn & ~mPrev;
                mPrev = iface.btn;
                eFail = 1'b0;
                eTimeout = 1'b0;
                if (mUnlockLeft > 0) begin
                    mUnlockLeft--;
                end else if (mLockLeft > 0) begin
                    mLockLeft--;
                    if (mLockLeft == 0) mFails = 0;
                end else if (press != 4'b0000) begin
                    mEntry.push_back(($countones(press) == 1) ? idxOf(press) : -1);
                    mIdle = 0;
                    if (mEntry.size() == 4) begin
                        good = 1'b1;
                        for (int k = 0; k < 4; k++) begin
                            if (mEntry[k] != codeSeq[k]) good = 1'b0;
                        end
                        mEntry.delete();
                        if (good) begin
                            mUnlockLeft = UL;
                            mFails = 0;
                        end else begin
                            mFails++;
                            eFail = 1'b1;
                            if (mFails == MF) mLockLeft = LK;
                        end
                    end
                end else if (mEntry.size() > 0) begin
                    mIdle++;
                    if (mIdle == TO) begin
                        eTimeout = 1'b1;
                        mEntry.delete();
                    end
                end
            end
        end
    end

    // Compare every output against the model on each falling edge and keep
    // pulse/duration tallies used by the hand-computed checks.
    initial begin
        forever begin
            @(negedge clkin);
            if (checkEn) begin
                checkOutput("unlock",     32'(iface.unlock),     32'(mUnlockLeft > 0));
                checkOutput("locked",     32'(iface.locked),     32'(mLockLeft > 0));
                checkOutput("fail",       32'(iface.fail),       32'(eFail));
                checkOutput("timeout",    32'(iface.timeout),    32'(eTimeout));
                checkOutput("digits",     32'(iface.digits),     32'(mEntry.size()));
                checkOutput("fail_count", 32'(iface.fail_count), 32'(mFails));
                if (iface.unlock === 1'b1) unlockHigh++;
                if (iface.locked === 1'b1) lockedHigh++;
                if (iface.fail === 1'b1) failPulses++;
                if (iface.timeout === 1'b1) begin
                    timeoutPulses++;
                    tTimeout = cyc;
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        miscompares++;
        $display("[TB] FAIL watchdog: time limit reached, got t=%0t, expected earlier finish", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios with hand-computed literal expectations.
    initial begin
        vectors = 0;
        miscompares = 0;
        checkEn = 1'b0;
        unlockHigh = 0;
        lockedHigh = 0;
        failPulses = 0;
        timeoutPulses = 0;
        tTimeout = 0;
        tPress = 0;
        iface.btn = 4'b0000;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clkin);
        checkEn = 1'b1;
        #1;
        checkOutput("reset_unlock", 32'(iface.unlock), 32'd0);
        checkOutput("reset_digits", 32'(iface.digits), 32'd0);
        reset = 1'b1;
        applyStimulus(4'b0000, 2);

        // Correct code: unlock for exactly UL cycles.
        unlockHigh = 0;
        enterCode(KA, KC, KD, KB);
        applyStimulus(4'b0000, 12);
        #1;
        checkOutput("unlock_cycles", 32'(unlockHigh), 32'd10);
        checkOutput("unlock_fail_count", 32'(iface.fail_count), 32'd0);
        checkOutput("unlock_digits", 32'(iface.digits), 32'd0);

        // Wrong code, then two more to reach lockout.
        failPulses = 0;
        unlockHigh = 0;
        enterCode(KA, KC, KC, KB);
        applyStimulus(4'b0000, 3);
        #1;
        checkOutput("fail_pulses_one", 32'(failPulses), 32'd1);
        checkOutput("fail_count_one", 32'(iface.fail_count), 32'd1);
        checkOutput("no_unlock_on_fail", 32'(unlockHigh), 32'd0);
        lockedHigh = 0;
        enterCode(KA, KC, KC, KB);
        enterCode(KA, KC, KC, KB);
        #1;
        checkOutput("locked_after_three", 32'(iface.locked), 32'd1);
        pressKey(KA, 5);
        pressKey(KC, 5);
        applyStimulus(4'b0000, 25);
        #1;
        checkOutput("locked_cycles", 32'(lockedHigh), 32'd30);
        checkOutput("lockout_clears_count", 32'(iface.fail_count), 32'd0);
        checkOutput("fail_pulses_three", 32'(failPulses), 32'd3);

        // Abandoned entry: timeout 20 cycles after the second press.
        enterCode(KA, KC, KC, KB);
        timeoutPulses = 0;
        pressKey(KA, 5);
        tPress = cyc + 1;
        applyStimulus(KC, 1);
        applyStimulus(4'b0000, 25);
        #1;
        checkOutput("timeout_pulses", 32'(timeoutPulses), 32'd1);
        checkOutput("timeout_delay", 32'(tTimeout - tPress), 32'd20);
        checkOutput("timeout_digits", 32'(iface.digits), 32'd0);
        checkOutput("timeout_fail_count", 32'(iface.fail_count), 32'd1);

        // a and c together count as a wrong first press.
        failPulses = 0;
        unlockHigh = 0;
        pressKey(KA | KC, 5);
        pressKey(KD, 5);
        pressKey(KB, 5);
        pressKey(KA, 5);
        #1;
        checkOutput("multi_fail_pulse", 32'(failPulses), 32'd1);
        checkOutput("multi_fail_count", 32'(iface.fail_count), 32'd2);
        checkOutput("multi_no_unlock", 32'(unlockHigh), 32'd0);

        // Button a held through reset release registers no press.
        iface.btn = KA;
        reset = 1'b0;
        applyStimulus(KA, 3);
        reset = 1'b1;
        applyStimulus(KA, 5);
        #1;
        checkOutput("held_through_reset", 32'(iface.digits), 32'd0);
        applyStimulus(4'b0000, 2);
        pressKey(KA, 3);
        #1;
        checkOutput("press_after_release", 32'(iface.digits), 32'd1);

        // Reset in the middle of an entry at three digits.
        pressKey(KC, 3);
        pressKey(KD, 3);
        #1;
        checkOutput("digits_three", 32'(iface.digits), 32'd3);
        failPulses = 0;
        timeoutPulses = 0;
        reset = 1'b0;
        @(negedge clkin);
        #1;
        checkOutput("reset_collect_digits", 32'(iface.digits), 32'd0);
        applyStimulus(4'b0000, 25);
        #1;
        checkOutput("reset_collect_no_pulse", 32'(failPulses + timeoutPulses), 32'd0);
        reset = 1'b1;
        applyStimulus(4'b0000, 2);

        // Reset in the middle of lockout.
        enterCode(KA, KC, KC, KB);
        enterCode(KA, KC, KC, KB);
        enterCode(KA, KC, KC, KB);
        #1;
        checkOutput("locked_before_reset", 32'(iface.locked), 32'd1);
        failPulses = 0;
        reset = 1'b0;
        @(negedge clkin);
        #1;
        checkOutput("reset_lockout_locked", 32'(iface.locked), 32'd0);
        checkOutput("reset_lockout_count", 32'(iface.fail_count), 32'd0);
        applyStimulus(4'b0000, 5);
        reset = 1'b1;
        applyStimulus(4'b0000, 40);
        #1;
        checkOutput("reset_lockout_no_pulse", 32'(failPulses + timeoutPulses), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
